// File: rtl/bus_arbiter.sv
// Round-robin 32-source bus arbiter with hold-time limit and one-cycle turnaround.
// Latency: grant registered one edge after a nonzero request seen in IDLE/TURN.
// Backpressure: none; an owner keeps the bus until release, request drop or expiry.
module bus_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] req,
    // "release" is a reserved word, hence the suffix
    input  logic        release_i,
    output logic [31:0] grant,
    output logic [4:0]  grant_idx,
    output logic        grant_valid,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam bit       HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t      state_q, state_d;
    logic [31:0] grant_q, grant_d;
    logic [4:0]  grant_idx_q, grant_idx_d;
    logic        grant_valid_q, grant_valid_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [4:0]  last_idx_q, last_idx_d;

    logic        win_found;
    logic [4:0]  win_idx;
    logic [4:0]  cand;
    logic        owner_req;
    logic        expire;

    // Search starts one past the previous winner; the final candidate is the previous winner itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_idx_q;
        cand      = '0;
        for (int i = 0; i < 32; i++) begin
            cand = last_idx_q + 5'(i + 1);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign owner_req = req[last_idx_q];
    assign expire    = HOLD_EN && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_d     = 1'b0;
        hold_cnt_d    = hold_cnt_q;
        last_idx_d    = last_idx_q;
        case (state_q)
            IDLE, TURN: begin
                if (win_found) begin
                    state_d       = GRANT;
                    grant_d       = 32'b1 << win_idx;
                    grant_idx_d   = win_idx;
                    grant_valid_d = 1'b1;
                    last_idx_d    = win_idx;
                end else begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                end
                hold_cnt_d = '0;
            end
            GRANT: begin
                if (release_i || !owner_req || expire) begin
                    state_d       = TURN;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                    // Forced removal only when nothing else would have ended the tenure
                    timeout_d     = expire && !release_i && owner_req;
                end
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
                hold_cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            hold_cnt_q    <= '0;
            last_idx_q    <= 5'd31;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            hold_cnt_q    <= hold_cnt_d;
            last_idx_q    <= last_idx_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule
